// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 raster timing constants and coordinate type
//
// Shared by the raster counters and the timing generator top. The constants
// are the defaults; the top re-exposes them as overridable parameters.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int unsigned COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_counter.sv
// rtl/vga_counter.sv - mod-N raster counter with enable and terminal-count flag
//
// Ports:
//   clk_vga    in   pixel clock
//   rst        in   synchronous active-high reset, clears count
//   en         in   advance the count this cycle
//   count      out  registered count, 0 .. N-1
//   count_next out  value count takes at the next edge (ignores rst)
//   tc         out  count == N-1 (independent of en)
module vga_counter
    import vga_pkg::*;
#(
    parameter int unsigned N = 800
) (
    input  logic   clk_vga,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output coord_t count_next,
    output logic   tc
);

    localparam coord_t LAST = coord_t'(N - 1);
    localparam coord_t ONE  = coord_t'(1);

    assign tc = (count == LAST);

    always_comb begin
        count_next = count;
        if (en) begin
            count_next = tc ? '0 : count + ONE;
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA raster timing generator
//
// Ports:
//   clk_vga     in   pixel clock, one pixel per clock
//   rst         in   synchronous active-high reset
//   HS, VS      out  horizontal / vertical sync, SYNC_ACTIVE during the pulse
//   pixel_x     out  current column, 0 .. H_TOTAL-1
//   pixel_y     out  current row, 0 .. V_TOTAL-1
//   blank       out  coordinate is outside the visible area
//   last_column out  pixel_x == H_VISIBLE-1
//   last_row    out  pixel_y == V_VISIBLE-1
//   frame_start out  one-cycle pulse at (0,0) after a completed frame
//   frame_count out  completed frames, wraps at 2^16
//   blink       out  toggles every BLINK_FRAMES frames
//
// Every decoded output is registered from the counters' next-state values,
// so it lands on the same edge as the coordinate it describes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE    = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FP         = vga_pkg::H_FP,
    parameter int unsigned H_SYNC       = vga_pkg::H_SYNC,
    parameter int unsigned H_BP         = vga_pkg::H_BP,
    parameter int unsigned V_VISIBLE    = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FP         = vga_pkg::V_FP,
    parameter int unsigned V_SYNC       = vga_pkg::V_SYNC,
    parameter int unsigned V_BP         = vga_pkg::V_BP,
    parameter logic        SYNC_ACTIVE  = 1'b0,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk_vga,
    input  logic        rst,
    output logic        HS,
    output logic        VS,
    output coord_t      pixel_x,
    output coord_t      pixel_y,
    output logic        blank,
    output logic        last_column,
    output logic        last_row,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        blink
);

    localparam int unsigned LINE_CLOCKS = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned FRAME_LINES = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (LINE_CLOCKS > 1024 || FRAME_LINES > 1024 ||
            H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_VISIBLE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
            BLINK_FRAMES < 1) begin : g_bad_params
            $error("vga_timing_gen: illegal timing parameters");
        end
    endgenerate

    localparam coord_t HS_ON  = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_OFF = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_ON  = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_OFF = coord_t'(V_VISIBLE + V_FP + V_SYNC);
    localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS  = coord_t'(V_VISIBLE);
    localparam coord_t H_LAST = coord_t'(H_VISIBLE - 1);
    localparam coord_t V_LAST = coord_t'(V_VISIBLE - 1);

    localparam int DIV_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    typedef logic [DIV_W-1:0] div_t;
    localparam div_t DIV_LAST = div_t'(BLINK_FRAMES - 1);
    localparam div_t DIV_ONE  = div_t'(1);

    coord_t x_next;
    coord_t y_next;
    logic   h_tc;
    logic   v_tc;
    logic   frame_wrap;
    div_t   blink_div;

    vga_counter #(.N(LINE_CLOCKS)) u_h_counter (
        .clk_vga    (clk_vga),
        .rst        (rst),
        .en         (1'b1),
        .count      (pixel_x),
        .count_next (x_next),
        .tc         (h_tc)
    );

    vga_counter #(.N(FRAME_LINES)) u_v_counter (
        .clk_vga    (clk_vga),
        .rst        (rst),
        .en         (h_tc),
        .count      (pixel_y),
        .count_next (y_next),
        .tc         (v_tc)
    );

    // Last pixel of the last line: the next edge returns the raster to (0,0).
    assign frame_wrap = h_tc & v_tc;

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            HS          <= ~SYNC_ACTIVE;
            VS          <= ~SYNC_ACTIVE;
            blank       <= 1'b0;
            last_column <= 1'b0;
            last_row    <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            blink_div   <= '0;
            blink       <= 1'b0;
        end else begin
            HS          <= (x_next >= HS_ON && x_next < HS_OFF) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            VS          <= (y_next >= VS_ON && y_next < VS_OFF) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            blank       <= (x_next >= H_VIS) || (y_next >= V_VIS);
            last_column <= (x_next == H_LAST);
            last_row    <= (y_next == V_LAST);
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_count <= frame_count + 16'd1;
                if (blink_div == DIV_LAST) begin
                    blink_div <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_div <= blink_div + DIV_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen, three timing configs
module tb_vga_timing_gen;

    localparam int NCYC = 20000;

    logic clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic        lc;
        logic        lr;
        logic        fs;
        logic        blink;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] fc;
    } obs_t;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    logic        hs_a, vs_a, blank_a, lc_a, lr_a, fs_a, blink_a;
    logic [9:0]  x_a, y_a;
    logic [15:0] fc_a;
    logic        hs_b, vs_b, blank_b, lc_b, lr_b, fs_b, blink_b;
    logic [9:0]  x_b, y_b;
    logic [15:0] fc_b;
    logic        hs_c, vs_c, blank_c, lc_c, lr_c, fs_c, blink_c;
    logic [9:0]  x_c, y_c;
    logic [15:0] fc_c;

    // Default 640x480, negative sync.
    vga_timing_gen u_a (
        .clk_vga(clk_vga), .rst(rst_a), .HS(hs_a), .VS(vs_a),
        .pixel_x(x_a), .pixel_y(y_a), .blank(blank_a),
        .last_column(lc_a), .last_row(lr_a), .frame_start(fs_a),
        .frame_count(fc_a), .blink(blink_a)
    );

    // Tiny raster, positive sync, 98-clock frame.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE(1'b1), .BLINK_FRAMES(2)
    ) u_b (
        .clk_vga(clk_vga), .rst(rst_b), .HS(hs_b), .VS(vs_b),
        .pixel_x(x_b), .pixel_y(y_b), .blank(blank_b),
        .last_column(lc_b), .last_row(lr_b), .frame_start(fs_b),
        .frame_count(fc_b), .blink(blink_b)
    );

    // Mid-size raster, negative sync, 544-clock frame.
    vga_timing_gen #(
        .H_VISIBLE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_VISIBLE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .SYNC_ACTIVE(1'b0), .BLINK_FRAMES(3)
    ) u_c (
        .clk_vga(clk_vga), .rst(rst_c), .HS(hs_c), .VS(vs_c),
        .pixel_x(x_c), .pixel_y(y_c), .blank(blank_c),
        .last_column(lc_c), .last_row(lr_c), .frame_start(fs_c),
        .frame_count(fc_c), .blink(blink_c)
    );

    obs_t obs_a, obs_b, obs_c;
    assign obs_a = {hs_a, vs_a, blank_a, lc_a, lr_a, fs_a, blink_a, x_a, y_a, fc_a};
    assign obs_b = {hs_b, vs_b, blank_b, lc_b, lr_b, fs_b, blink_b, x_b, y_b, fc_b};
    assign obs_c = {hs_c, vs_c, blank_c, lc_c, lr_c, fs_c, blink_c, x_c, y_c, fc_c};

    int checks   = 0;
    int failures = 0;

    obs_t q0[$];
    obs_t q1[$];
    obs_t q2[$];

    // Outputs for a raster that has run t clocks since leaving (0,0) after reset.
    function automatic obs_t model(input int cfg, input int unsigned t);
        int unsigned hv, hf, hsn, hb, vv, vf, vsn, vb, bf;
        int unsigned ht, vt, x, y, frames;
        logic sa;
        obs_t o;
        case (cfg)
            0: begin
                hv = 640; hf = 16; hsn = 96; hb = 48;
                vv = 480; vf = 10; vsn = 2;  vb = 33; sa = 1'b0; bf = 30;
            end
            1: begin
                hv = 8; hf = 2; hsn = 2; hb = 2;
                vv = 4; vf = 1; vsn = 1; vb = 1; sa = 1'b1; bf = 2;
            end
            default: begin
                hv = 20; hf = 3; hsn = 5; hb = 4;
                vv = 10; vf = 2; vsn = 3; vb = 2; sa = 1'b0; bf = 3;
            end
        endcase
        ht     = hv + hf + hsn + hb;
        vt     = vv + vf + vsn + vb;
        x      = t % ht;
        y      = (t / ht) % vt;
        frames = t / (ht * vt);
        o.x     = 10'(x);
        o.y     = 10'(y);
        o.hs    = (x >= hv + hf && x < hv + hf + hsn) ? sa : ~sa;
        o.vs    = (y >= vv + vf && y < vv + vf + vsn) ? sa : ~sa;
        o.blank = (x >= hv) || (y >= vv);
        o.lc    = (x == hv - 1);
        o.lr    = (y == vv - 1);
        o.fs    = (t != 0) && (t % (ht * vt) == 0);
        o.fc    = 16'(frames);
        o.blink = ((frames / bf) % 2) == 1;
        return o;
    endfunction

    task automatic push(input int cfg, input obs_t e);
        case (cfg)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic check(input int cfg, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL dut%0d raster at %0t: got x=%0d y=%0d hs=%b vs=%b blank=%b lc=%b lr=%b fs=%b blink=%b fc=%0d, want x=%0d y=%0d hs=%b vs=%b blank=%b lc=%b lr=%b fs=%b blink=%b fc=%0d",
                     cfg, $time, act.x, act.y, act.hs, act.vs, act.blank, act.lc, act.lr, act.fs, act.blink, act.fc,
                     exp.x, exp.y, exp.hs, exp.vs, exp.blank, exp.lc, exp.lr, exp.fs, exp.blink, exp.fc);
        end
    endtask

    // Monitor: free-running outputs are presented every cycle.
    initial begin
        forever begin
            @(negedge clk_vga);
            if (q0.size() > 0) check(0, obs_a, q0.pop_front());
            if (q1.size() > 0) check(1, obs_b, q1.pop_front());
            if (q2.size() > 0) check(2, obs_c, q2.pop_front());
        end
    end

    // Stimulus: random reset pulses; expectation pushed for the coming edge.
    initial begin
        int unsigned t_m [3];
        int          rem [3];
        logic        r;
        int          drain;
        for (int i = 0; i < 3; i++) begin
            rem[i] = 2;
            t_m[i] = 0;
            push(i, model(i, 0));
        end
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk_vga);
            #2;
            for (int i = 0; i < 3; i++) begin
                if (rem[i] > 0) begin
                    r = 1'b1;
                    rem[i]--;
                end else if (cyc == 6000 + 1700 * i || $urandom_range(0, 2999) == 0) begin
                    r = 1'b1;
                    rem[i] = int'($urandom_range(0, 2));
                end else begin
                    r = 1'b0;
                end
                t_m[i] = r ? 0 : t_m[i] + 1;
                case (i)
                    0:       rst_a = r;
                    1:       rst_b = r;
                    default: rst_c = r;
                endcase
                push(i, model(i, t_m[i]));
            end
        end
        drain = 0;
        while ((q0.size() + q1.size() + q2.size()) > 0 && drain < 5) begin
            @(posedge clk_vga);
            #3;
            drain++;
        end
        checks++;
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q0.size() + q1.size() + q2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
